// File: rtl/spi_pkg.sv
// Shared types for the SPI serialiser/deserialiser stage.
// Frame FSM encoding and the default frame width.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } shift_state_t;

    localparam int SPI_DATA_W = 8;

endpackage

// File: rtl/spi_shift_register.sv
// SPI shift register: serialises a parallel byte on mosi and
// deserialises miso, paced by strobes from the baud stage.
// Optional macro SPI_SHIFT_OVERRUN_EN adds rd_ack/overrun.
module spi_shift_register
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              start,
    input  logic              ss,
    input  logic              lsbfe,
    input  logic [DATA_W-1:0] data_mosi,
    input  logic              shift_stb,
    input  logic              sample_stb,
    input  logic              miso,
`ifdef SPI_SHIFT_OVERRUN_EN
    input  logic              rd_ack,
    output logic              overrun,
`endif
    output logic              mosi,
    output logic              busy,
    output logic [DATA_W-1:0] receive_data,
    output logic              tx_done
);

    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_W);

    shift_state_t      state_q, state_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CW-1:0]     scnt_q, scnt_d;
    logic [CW-1:0]     hcnt_q, hcnt_d;
    logic              lsb_q, lsb_d;
    logic              mosi_q, mosi_d;

    // Frame sequencing, shift/sample datapath and bit counting
    always_comb begin
        state_d = state_q;
        tx_sr_d = tx_sr_q;
        rx_sr_d = rx_sr_q;
        rdata_d = rdata_q;
        scnt_d  = scnt_q;
        hcnt_d  = hcnt_q;
        lsb_d   = lsb_q;
        mosi_d  = mosi_q;
        unique case (state_q)
            IDLE: begin
                if (start && !ss) begin
                    state_d = LOAD;
                    tx_sr_d = data_mosi;
                    rx_sr_d = '0;
                    scnt_d  = '0;
                    hcnt_d  = '0;
                    lsb_d   = lsbfe;
                    mosi_d  = lsbfe ? data_mosi[0]
                                    : data_mosi[DATA_W-1];
                end
            end
            LOAD: begin
                if (ss) begin
                    state_d = IDLE;
                    mosi_d  = 1'b0;
                end else begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (ss) begin
                    state_d = IDLE;
                    mosi_d  = 1'b0;
                end else if (scnt_q == FULL) begin
                    state_d = DONE;
                    rdata_d = rx_sr_q;
                end else begin
                    if (sample_stb) begin
                        rx_sr_d = lsb_q
                            ? {miso, rx_sr_q[DATA_W-1:1]}
                            : {rx_sr_q[DATA_W-2:0], miso};
                        scnt_d = scnt_q + 1'b1;
                    end
                    if (shift_stb && (hcnt_q < LAST)) begin
                        tx_sr_d = lsb_q ? (tx_sr_q >> 1)
                                        : (tx_sr_q << 1);
                        mosi_d  = lsb_q ? tx_sr_q[1]
                                        : tx_sr_q[DATA_W-2];
                        hcnt_d  = hcnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            tx_sr_q <= '0;
            rx_sr_q <= '0;
            rdata_q <= '0;
            scnt_q  <= '0;
            hcnt_q  <= '0;
            lsb_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_sr_q <= tx_sr_d;
            rx_sr_q <= rx_sr_d;
            rdata_q <= rdata_d;
            scnt_q  <= scnt_d;
            hcnt_q  <= hcnt_d;
            lsb_q   <= lsb_d;
            mosi_q  <= mosi_d;
        end
    end

    assign mosi         = mosi_q;
    assign receive_data = rdata_q;
    assign busy         = (state_q == LOAD) ||
                          (state_q == XFER);
    assign tx_done      = (state_q == DONE);

`ifdef SPI_SHIFT_OVERRUN_EN
    logic unread_q, unread_d;
    logic ovr_q, ovr_d;

    // Track whether the held byte was read before the next lands
    always_comb begin
        unread_d = unread_q;
        ovr_d    = ovr_q;
        if (state_q == DONE) begin
            unread_d = 1'b1;
            if (rd_ack) begin
                ovr_d = 1'b0;
            end else if (unread_q) begin
                ovr_d = 1'b1;
            end
        end else if (rd_ack) begin
            unread_d = 1'b0;
            ovr_d    = 1'b0;
        end
    end

    // Overrun bookkeeping registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            unread_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            unread_q <= unread_d;
            ovr_q    <= ovr_d;
        end
    end

    assign overrun = ovr_q;
`endif

endmodule
